ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage pipeline. It sits directly downstream of the ID/EX register and consumes the `forward_a`/`forward_b` selects produced by the forwarding unit. The stage applies operand forwarding and computes single-cycle ALU results. It runs an iterative 32-cycle multiply/divide engine that stalls upstream while busy, and it owns the EX/MEM pipeline register.

## Interface
Parameters:
- `XLEN`, 32, datapath width; engine iteration count equals `XLEN`.

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `id_valid`  in  1  ID/EX holds a live instruction.
- `id_alu_op`  in  4  operation code, listed under Operation.
- `id_rs_data`, `id_rt_data`  in  XLEN  register-file operands.
- `id_imm`  in  XLEN  sign-extended immediate.
- `id_alu_src`  in  1  1: B operand = `id_imm`.
- `id_rd`  in  5  destination register.
- `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1  control fields passed through to EX/MEM.
- `forward_a`, `forward_b`  in  2  select codes:
  - 00: register-file operand.
  - 10: `ex_mem_alu_result`.
  - 01: `wb_data`.
  - 11: treated as 00.
- `wb_data`  in  XLEN  MEM/WB writeback value.
- `flush`  in  1  squash the instruction in EX.
- `ex_busy`  out  1  stall request to the hazard unit and the ID/EX register.
- `ex_mem_valid`, `ex_mem_reg_write`, `ex_mem_mem_read`, `ex_mem_mem_write`  out  1  registered control outputs.
- `ex_mem_alu_result`  out  XLEN  registered result.
- `ex_mem_store_data`  out  XLEN  registered forwarded B operand, taken before the immediate mux.
- `ex_mem_rd`  out  5  registered destination register.

## Operation
- Forwarded operands:
  - `A` = fwd(`id_rs_data`, `forward_a`).
  - `Bf` = fwd(`id_rt_data`, `forward_b`).
  - `B` = `id_alu_src` ? `id_imm` : `Bf`.
- Single-cycle ops:
  - 0 ADD, 1 SUB (both wrap modulo 2^XLEN).
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLT: signed compare, result 1 or 0.
  - 6 SLL, 7 SRL: shift amount `B[4:0]`.
  - 11–15: result 0.
- Multi-cycle ops, all unsigned:
  - 8 MUL: low XLEN bits of A*B, shift-add.
  - 9 DIVU: quotient, restoring division.
  - 10 REMU: remainder.
- Divide by zero: DIVU returns all-ones; REMU returns A.
- Engine FSM, states IDLE, RUN, DONE:
  - IDLE: if `id_valid` and op is 8–10 and not `flush`, capture A, B and op, clear the counter, go to RUN.
  - RUN: one iteration per cycle; after iteration `XLEN`-1, go to DONE.
  - DONE: go to IDLE.
- `ex_busy` is combinational. It is 1 in the IDLE start cycle and in every RUN cycle. It is 0 in DONE and in every other case.
- EX/MEM load priority, highest first:
  1. `!rst_n` or `flush`: all outputs 0.
  2. `ex_busy`: bubble. `valid`, `reg_write`, `mem_read` and `mem_write` are 0; data fields hold their previous values.
  3. DONE: engine result plus the held ID/EX control fields.
  4. Otherwise: single-cycle result, `Bf`, and the control fields gated by `id_valid`.
- `flush` in any state aborts the engine to IDLE and loads a bubble.
- Reset mid-operation forces IDLE, `ex_busy`=0, and all EX/MEM outputs 0.

## Timing
- Reset value of every output is 0.
- Single-cycle op: operands are sampled at edge T; the result is visible on `ex_mem_*` after edge T.
- Multi-cycle op: it starts in cycle T with `ex_busy`=1, RUN covers T+1..T+XLEN, and DONE is in cycle T+XLEN+1. The result is registered at the end of that cycle, for a total of XLEN+2 cycles from issue. Upstream advances on the DONE edge.
- Operands for multi-cycle ops are latched at start. Forwarding source changes during the stall are ignored.
- Back-to-back multi-cycle ops: the second one starts in the IDLE cycle that follows DONE, with no extra gap.
- `flush` together with a start: no start occurs, and a bubble is loaded.

## Test plan
- ADD with `forward_a`=10: `ex_mem_alu_result`=5, `id_rt_data`=7 -> `ex_mem_alu_result`=12 one cycle later, `ex_mem_valid`=1.
- SLT with A=0xFFFFFFFF, B=1 -> 1. SRL of 0x80000000 by 31 -> 1. SUB 0-1 -> 0xFFFFFFFF.
- MUL 0x10000 * 0x10001 -> 0x00010000 after exactly 34 cycles. `ex_busy` is high for 33 cycles and EX/MEM shows bubbles meanwhile.
- DIVU 100/7 -> 14; REMU -> 2. DIVU x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
- `flush` asserted in RUN cycle 10 -> `ex_busy` is 0 the next cycle and the EX/MEM bubble has `reg_write`=0. A following ADD completes normally.
- `rst_n`=0 during RUN -> all outputs 0 after the edge. A new MUL started after reset yields the correct product.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the 5-stage pipeline.
//
// Resolves operand forwarding and computes single-cycle ALU results. A 32-step
// iterative engine (shift-add multiply, restoring divide) handles MUL, DIVU and
// REMU. It stalls upstream through ex_busy while it runs. The stage owns the
// EX/MEM pipeline register.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   id_valid .. id_mem_write   ID/EX register contents (instruction in EX)
//   forward_a, forward_b       operand select: 10 EX/MEM result, 01 WB data,
//                              00/11 register file
//   wb_data                    MEM/WB writeback value
//   flush                      squash the instruction in EX and abort the engine
//   ex_busy                    combinational stall request
//   ex_mem_*                   EX/MEM pipeline register outputs
module ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [3:0]      id_alu_op,
   input  logic [XLEN-1:0] id_rs_data,
   input  logic [XLEN-1:0] id_rt_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic            id_alu_src,
   input  logic [4:0]      id_rd,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic [1:0]      forward_a,
   input  logic [1:0]      forward_b,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            ex_busy,
   output logic            ex_mem_valid,
   output logic            ex_mem_reg_write,
   output logic            ex_mem_mem_read,
   output logic            ex_mem_mem_write,
   output logic [XLEN-1:0] ex_mem_alu_result,
   output logic [XLEN-1:0] ex_mem_store_data,
   output logic [4:0]      ex_mem_rd
);

   localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_reg, state_next;

   // ---------------- operand forwarding ----------------
   logic [XLEN-1:0] rf_op  [2];
   logic [1:0]      fwd_sel[2];
   logic [XLEN-1:0] fwd_op [2];

   assign rf_op[0]   = id_rs_data;
   assign rf_op[1]   = id_rt_data;
   assign fwd_sel[0] = forward_a;
   assign fwd_sel[1] = forward_b;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         assign fwd_op[gi] = (fwd_sel[gi] == 2'b10) ? ex_mem_alu_result :
                             (fwd_sel[gi] == 2'b01) ? wb_data : rf_op[gi];
      end
   endgenerate

   logic [XLEN-1:0] a_op, bf_op, b_op;
   assign a_op  = fwd_op[0];
   assign bf_op = fwd_op[1];
   assign b_op  = id_alu_src ? id_imm : bf_op;

   // ---------------- single-cycle ALU ----------------
   logic [XLEN-1:0] alu_result;
   always_comb begin
      alu_result = '0;
      case (id_alu_op)
         4'd0: alu_result = a_op + b_op;
         4'd1: alu_result = a_op - b_op;
         4'd2: alu_result = a_op & b_op;
         4'd3: alu_result = a_op | b_op;
         4'd4: alu_result = a_op ^ b_op;
         4'd5: alu_result = {{(XLEN-1){1'b0}}, ($signed(a_op) < $signed(b_op))};
         4'd6: alu_result = a_op << b_op[4:0];
         4'd7: alu_result = a_op >> b_op[4:0];
         default: alu_result = '0;
      endcase
   end

   // ---------------- iterative engine ----------------
   logic            is_multi, start;
   logic [3:0]      op_reg;
   logic [CW-1:0]   cnt_reg;
   // MUL: a_reg = shifting multiplicand, b_reg = shifting multiplier, acc_reg = product.
   // DIV: a_reg = dividend shifting out / quotient shifting in, b_reg = divisor,
   //      acc_reg = partial remainder.
   logic [XLEN-1:0] a_reg, b_reg, acc_reg;
   logic [XLEN-1:0] hold_store_reg;
   logic [4:0]      hold_rd_reg;
   logic            hold_reg_write_reg, hold_mem_read_reg, hold_mem_write_reg;
   logic [XLEN:0]   rem_shift, rem_diff;
   logic [XLEN-1:0] engine_result;

   assign is_multi = (id_alu_op == 4'd8) || (id_alu_op == 4'd9) || (id_alu_op == 4'd10);
   assign start    = (state_reg == IDLE) && id_valid && is_multi && !flush;
   assign ex_busy  = rst_n && (start || (state_reg == RUN));

   // A zero divisor needs no special case: every step subtracts zero, so the
   // quotient fills with ones and the remainder ends up equal to the dividend.
   assign rem_shift = {acc_reg, a_reg[XLEN-1]};
   assign rem_diff  = rem_shift - {1'b0, b_reg};

   always_comb begin
      engine_result = acc_reg;
      if (op_reg == 4'd9) engine_result = a_reg;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (cnt_reg == CW'(XLEN-1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg          <= IDLE;
         cnt_reg            <= '0;
         op_reg             <= '0;
         a_reg              <= '0;
         b_reg              <= '0;
         acc_reg            <= '0;
         hold_store_reg     <= '0;
         hold_rd_reg        <= '0;
         hold_reg_write_reg <= 1'b0;
         hold_mem_read_reg  <= 1'b0;
         hold_mem_write_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (start) begin
            // Operands and control are latched here; later forwarding changes are ignored.
            op_reg             <= id_alu_op;
            a_reg              <= a_op;
            b_reg              <= b_op;
            acc_reg            <= '0;
            cnt_reg            <= '0;
            hold_store_reg     <= bf_op;
            hold_rd_reg        <= id_rd;
            hold_reg_write_reg <= id_reg_write;
            hold_mem_read_reg  <= id_mem_read;
            hold_mem_write_reg <= id_mem_write;
         end else if (state_reg == RUN) begin
            cnt_reg <= cnt_reg + CW'(1);
            if (op_reg == 4'd8) begin
               acc_reg <= acc_reg + (b_reg[0] ? a_reg : '0);
               a_reg   <= a_reg << 1;
               b_reg   <= b_reg >> 1;
            end else if (!rem_diff[XLEN]) begin
               acc_reg <= rem_diff[XLEN-1:0];
               a_reg   <= {a_reg[XLEN-2:0], 1'b1};
            end else begin
               acc_reg <= rem_shift[XLEN-1:0];
               a_reg   <= {a_reg[XLEN-2:0], 1'b0};
            end
         end
      end
   end

   // ---------------- EX/MEM register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         ex_mem_valid      <= 1'b0;
         ex_mem_reg_write  <= 1'b0;
         ex_mem_mem_read   <= 1'b0;
         ex_mem_mem_write  <= 1'b0;
         ex_mem_alu_result <= '0;
         ex_mem_store_data <= '0;
         ex_mem_rd         <= '0;
      end else if (ex_busy) begin
         // Bubble: control cleared, data fields keep their last values.
         ex_mem_valid     <= 1'b0;
         ex_mem_reg_write <= 1'b0;
         ex_mem_mem_read  <= 1'b0;
         ex_mem_mem_write <= 1'b0;
      end else if (state_reg == DONE) begin
         ex_mem_valid      <= 1'b1;
         ex_mem_reg_write  <= hold_reg_write_reg;
         ex_mem_mem_read   <= hold_mem_read_reg;
         ex_mem_mem_write  <= hold_mem_write_reg;
         ex_mem_alu_result <= engine_result;
         ex_mem_store_data <= hold_store_reg;
         ex_mem_rd         <= hold_rd_reg;
      end else begin
         ex_mem_valid      <= id_valid;
         ex_mem_reg_write  <= id_valid & id_reg_write;
         ex_mem_mem_read   <= id_valid & id_mem_read;
         ex_mem_mem_write  <= id_valid & id_mem_write;
         ex_mem_alu_result <= alu_result;
         ex_mem_store_data <= bf_op;
         ex_mem_rd         <= id_rd;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage -- self-checking bench for ex_stage. Directed and randomized
// transactions are compared against an arithmetic reference model.
module tb_ex_stage;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            id_valid;
   logic [3:0]      id_alu_op;
   logic [XLEN-1:0] id_rs_data, id_rt_data, id_imm;
   logic            id_alu_src;
   logic [4:0]      id_rd;
   logic            id_reg_write, id_mem_read, id_mem_write;
   logic [1:0]      forward_a, forward_b;
   logic [XLEN-1:0] wb_data;
   logic            flush;
   logic            ex_busy;
   logic            ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
   logic [XLEN-1:0] ex_mem_alu_result, ex_mem_store_data;
   logic [4:0]      ex_mem_rd;

   ex_stage #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_alu_src(id_alu_src), .id_rd(id_rd), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .forward_a(forward_a), .forward_b(forward_b), .wb_data(wb_data),
      .flush(flush), .ex_busy(ex_busy), .ex_mem_valid(ex_mem_valid),
      .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
      .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_alu_result(ex_mem_alu_result),
      .ex_mem_store_data(ex_mem_store_data), .ex_mem_rd(ex_mem_rd)
   );

   always #5 clk = ~clk;

   int n_compared   = 0;
   int n_mismatched = 0;
   logic [31:0] m_alu_result = '0;   // model of the current EX/MEM result

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:    return a << b[4:0];
         4'd7:    return a >> b[4:0];
         4'd8:    return a * b;
         4'd9:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'd10:   return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] fwd_model(input logic [31:0] rf, input logic [1:0] sel,
                                             input logic [31:0] wb);
      if (sel == 2'b10) return m_alu_result;
      if (sel == 2'b01) return wb;
      return rf;
   endfunction

   // Present one instruction; returns expected A, Bf and B.
   task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] imm, input logic src, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [31:0] wb, input logic [4:0] rd,
                        input logic [2:0] ctl, output logic [31:0] a, output logic [31:0] bf,
                        output logic [31:0] b);
      a  = fwd_model(rs, fa, wb);
      bf = fwd_model(rt, fb, wb);
      b  = src ? imm : bf;
      id_valid = 1'b1; id_alu_op = op; id_rs_data = rs; id_rt_data = rt; id_imm = imm;
      id_alu_src = src; forward_a = fa; forward_b = fb; wb_data = wb; id_rd = rd;
      {id_reg_write, id_mem_read, id_mem_write} = ctl;
   endtask

   task automatic do_single(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] imm, input logic src, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [31:0] wb);
      logic [31:0] a, bf, b, exp;
      logic [4:0]  rd;
      logic [2:0]  ctl;
      rd  = 5'($urandom);
      ctl = 3'($urandom);
      drive(op, rs, rt, imm, src, fa, fb, wb, rd, ctl, a, bf, b);
      exp = ref_alu(op, a, b);
      #1 check_val("single_busy", 32'(ex_busy), 32'd0);
      @(posedge clk); #1;
      check_val("single_valid", 32'(ex_mem_valid), 32'd1);
      check_val("single_result", ex_mem_alu_result, exp);
      check_val("single_store", ex_mem_store_data, bf);
      check_val("single_rd", 32'(ex_mem_rd), 32'(rd));
      check_val("single_ctl", 32'({ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write}), 32'(ctl));
      $display("single op=%0d a=%h b=%h -> %h (exp %h)", op, a, b, ex_mem_alu_result, exp);
      m_alu_result = exp;
      id_valid = 1'b0;
   endtask

   task automatic do_multi(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] imm, input logic src, input logic [1:0] fa,
                           input logic [1:0] fb, input logic [31:0] wb);
      logic [31:0] a, bf, b, exp;
      logic [4:0]  rd;
      logic [2:0]  ctl;
      int n;
      rd  = 5'($urandom);
      ctl = 3'($urandom);
      drive(op, rs, rt, imm, src, fa, fb, wb, rd, ctl, a, bf, b);
      exp = ref_alu(op, a, b);
      #1 check_val("multi_busy_start", 32'(ex_busy), 32'd1);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         check_val("multi_bubble_valid", 32'(ex_mem_valid), 32'd0);
         check_val("multi_bubble_hold", ex_mem_alu_result, m_alu_result);
         // Scramble forwarding sources; latched operands must be unaffected.
         wb_data   = $urandom;
         forward_a = 2'($urandom);
         forward_b = 2'($urandom);
      end while (ex_busy && n < 100);
      check_val("multi_busy_cycles", 32'(n), 32'(XLEN + 1));
      @(posedge clk); #1;
      id_valid = 1'b0;
      check_val("multi_valid", 32'(ex_mem_valid), 32'd1);
      check_val("multi_result", ex_mem_alu_result, exp);
      check_val("multi_rd", 32'(ex_mem_rd), 32'(rd));
      check_val("multi_ctl", 32'({ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write}), 32'(ctl));
      $display("multi op=%0d a=%h b=%h -> %h (exp %h) busy=%0d", op, a, b, ex_mem_alu_result, exp, n);
      m_alu_result = exp;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_busy"}, 32'(ex_busy), 32'd0);
      check_val({tag, "_ctl"}, 32'({ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read,
                                    ex_mem_mem_write}), 32'd0);
      check_val({tag, "_result"}, ex_mem_alu_result, 32'd0);
      check_val({tag, "_store"}, ex_mem_store_data, 32'd0);
      check_val({tag, "_rd"}, 32'(ex_mem_rd), 32'd0);
   endtask

   initial begin
      logic [31:0] a, bf, b;
      logic [3:0]  op;
      logic [31:0] rt;
      rst_n = 1'b0; id_valid = 1'b0; id_alu_op = '0; id_rs_data = '0; id_rt_data = '0;
      id_imm = '0; id_alu_src = 1'b0; id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
      id_mem_write = 1'b0; forward_a = '0; forward_b = '0; wb_data = '0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      $display("reset state checked");
      rst_n = 1'b1;

      // Directed single-cycle cases
      do_single(4'd0, 32'd2, 32'd0, 32'd3, 1'b1, 2'b00, 2'b00, 32'd0);              // 5
      do_single(4'd0, 32'd99, 32'd7, 32'd0, 1'b0, 2'b10, 2'b00, 32'd0);             // 5+7=12
      do_single(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0);      // 1
      do_single(4'd7, 32'h8000_0000, 32'd31, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0);     // 1
      do_single(4'd1, 32'd0, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0);              // FFFFFFFF
      do_single(4'd13, 32'd5, 32'd6, 32'd0, 1'b0, 2'b11, 2'b11, 32'd0);             // 0
      do_single(4'd6, 32'd3, 32'd0, 32'd0, 1'b0, 2'b01, 2'b00, 32'h0000_0024);      // 3<<4... wb as B? no: rs forwarded

      // Directed multi-cycle cases (back-to-back, no gap between them)
      do_multi(4'd8, 32'h0001_0000, 32'h0001_0001, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0);
      do_multi(4'd9, 32'd100, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0);
      do_multi(4'd10, 32'd100, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0);
      do_multi(4'd9, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0);
      do_multi(4'd10, 32'd9, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0);

      // Flush in RUN cycle 10
      drive(4'd8, 32'd3, 32'd5, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd9, 3'b100, a, bf, b);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1; id_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      check_val("flush_busy", 32'(ex_busy), 32'd0);
      check_val("flush_valid", 32'(ex_mem_valid), 32'd0);
      check_val("flush_reg_write", 32'(ex_mem_reg_write), 32'd0);
      check_val("flush_result", ex_mem_alu_result, 32'd0);
      $display("flush during RUN checked");
      m_alu_result = '0;
      do_single(4'd0, 32'd40, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0);

      // Flush together with a start
      drive(4'd9, 32'd50, 32'd5, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd3, 3'b100, a, bf, b);
      flush = 1'b1;
      #1 check_val("flush_start_busy", 32'(ex_busy), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      check_val("flush_start_valid", 32'(ex_mem_valid), 32'd0);
      $display("flush with start checked");
      m_alu_result = '0;
      do_single(4'd3, 32'h0F0F_0000, 32'h0000_F0F0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0);

      // Reset during RUN
      drive(4'd8, 32'd11, 32'd13, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd4, 3'b111, a, bf, b);
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      check_all_zero("mid_reset");
      $display("reset during RUN checked");
      rst_n = 1'b1; id_valid = 1'b0;
      m_alu_result = '0;
      do_multi(4'd8, 32'd12345, 32'd678, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0);

      // Randomized single-cycle ops
      for (int i = 0; i < 30; i++) begin
         do op = 4'($urandom_range(0, 15)); while (op >= 4'd8 && op <= 4'd10);
         do_single(op, $urandom, $urandom, $urandom, 1'($urandom), 2'($urandom),
                   2'($urandom), $urandom);
      end

      // Randomized multi-cycle ops, including zero divisors
      for (int i = 0; i < 8; i++) begin
         op = 4'($urandom_range(8, 10));
         rt = (i % 4 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
         do_multi(op, $urandom, rt, $urandom, 1'b0, 2'($urandom), 2'b00, $urandom);
      end
      do_single(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 2'b10, 2'b00, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
